// File: rtl/unidad_adelanto_comparacion_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unidad_adelanto_comparacion_pkg
// Description : Shared selector encodings, shadow-slot type and match helper
//               for the branch-comparison forwarding controller.
// Revision    : 1.0 - initial release
// ============================================================================
package unidad_adelanto_comparacion_pkg;

    // Widest register index a shadow slot can carry; narrower indices are
    // zero-extended into this field by the top level.
    localparam int c_RD_MAX_W = 8;

    // Comparison-mux selector encodings
    localparam logic [1:0] SEL_DECO = 2'b00;
    localparam logic [1:0] SEL_EXE  = 2'b01;
    localparam logic [1:0] SEL_MEM  = 2'b10;

    // Shadow pipeline slot: destination tag of the instruction in a stage
    typedef struct packed {
        logic                  valid;
        logic [c_RD_MAX_W-1:0] rd;
        logic                  load;
    } slot_t;

    // A slot supplies a source only when it writes that register; r0 is
    // hard-wired to zero and is never forwarded.
    function automatic logic slot_match(input slot_t slot,
                                        input logic [c_RD_MAX_W-1:0] src);
        return slot.valid && (slot.rd == src) && (src != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/unidad_adelanto_comparacion_sel_adelanto.sv
`default_nettype none
// ============================================================================
// Module      : sel_adelanto
// Description : Per-source forwarding selector. Picks the youngest producer
//               of the source register among the EXE and MEM shadow slots and
//               flags a load in EXE that cannot be forwarded yet.
// Revision    : 1.0 - initial release
// ============================================================================
module sel_adelanto
    import unidad_adelanto_comparacion_pkg::*;
(
    input  logic [c_RD_MAX_W-1:0] i_src,
    input  slot_t                 i_exe,
    input  slot_t                 i_mem,
    output logic [1:0]            o_sel,
    output logic                  o_load_hit
);

    logic w_exe_hit;
    logic w_mem_hit;

    assign w_exe_hit = slot_match(i_exe, i_src);
    assign w_mem_hit = slot_match(i_mem, i_src);

    // EXE is younger so it wins; an EXE load has no data yet and must stall,
    // while MEM data is already valid for both loads and ALU ops.
    always_comb begin
        o_sel      = SEL_DECO;
        o_load_hit = 1'b0;
        if (w_exe_hit) begin
            if (i_exe.load) begin
                o_load_hit = 1'b1;
            end else begin
                o_sel = SEL_EXE;
            end
        end else if (w_mem_hit) begin
            o_sel = SEL_MEM;
        end
    end

endmodule
`default_nettype wire

// File: rtl/unidad_adelanto_comparacion.sv
`default_nettype none
// ============================================================================
// Module      : unidad_adelanto_comparacion
// Description : Forwarding and load-use hazard controller for the branch
//               comparison operand muxes in DECO. Tracks destination tags of
//               EXE and MEM, drives the Rs/Rt mux selectors, raises Stall on a
//               branch that depends on a load still in EXE and counts stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module unidad_adelanto_comparacion
    import unidad_adelanto_comparacion_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Avanza,
    input  logic             Flush,
    input  logic [REG_W-1:0] Rs_Deco_Id,
    input  logic [REG_W-1:0] Rt_Deco_Id,
    input  logic             Es_Branch,
    input  logic             Usa_Rt,
    input  logic [REG_W-1:0] Rd_Deco_Id,
    input  logic             RegWrite_Deco,
    input  logic             MemRead_Deco,
    output logic [1:0]       Sel_Rs,
    output logic [1:0]       Sel_Rt,
    output logic             Stall,
    output logic [CNT_W-1:0] Cnt_Stall
);

    slot_t                 r_exe;
    slot_t                 r_mem;
    logic [CNT_W-1:0]      r_cnt;

    logic [c_RD_MAX_W-1:0] w_rs_ext;
    logic [c_RD_MAX_W-1:0] w_rt_ext;
    slot_t                 w_deco_slot;
    logic [1:0]            w_sel_rs;
    logic [1:0]            w_sel_rt;
    logic                  w_hit_rs;
    logic                  w_hit_rt;
    logic                  w_stall;

    // Widen DECO register indices to the slot tag width
    always_comb begin
        w_rs_ext              = '0;
        w_rt_ext              = '0;
        w_deco_slot           = '0;
        w_rs_ext[REG_W-1:0]   = Rs_Deco_Id;
        w_rt_ext[REG_W-1:0]   = Rt_Deco_Id;
        w_deco_slot.valid     = RegWrite_Deco;
        w_deco_slot.rd[REG_W-1:0] = Rd_Deco_Id;
        w_deco_slot.load      = MemRead_Deco;
    end

    sel_adelanto u_sel_rs (
        .i_src      (w_rs_ext),
        .i_exe      (r_exe),
        .i_mem      (r_mem),
        .o_sel      (w_sel_rs),
        .o_load_hit (w_hit_rs)
    );

    sel_adelanto u_sel_rt (
        .i_src      (w_rt_ext),
        .i_exe      (r_exe),
        .i_mem      (r_mem),
        .o_sel      (w_sel_rt),
        .o_load_hit (w_hit_rt)
    );

    // Only branches use the comparison muxes; rt is ignored for rs-vs-zero
    always_comb begin
        w_stall = Es_Branch && (w_hit_rs || (Usa_Rt && w_hit_rt));
        Sel_Rs  = Es_Branch ? w_sel_rs : SEL_DECO;
        Sel_Rt  = (Es_Branch && Usa_Rt) ? w_sel_rt : SEL_DECO;
    end

    assign Stall     = w_stall;
    assign Cnt_Stall = r_cnt;

    // Shadow pipeline and saturating stall counter; everything freezes
    // while the pipeline is not advancing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exe <= '0;
            r_mem <= '0;
            r_cnt <= '0;
        end else if (Avanza) begin
            r_mem <= r_exe;
            if (w_stall || Flush) begin
                r_exe <= '0;
            end else begin
                r_exe <= w_deco_slot;
            end
            if (w_stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unidad_adelanto_comparacion.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidad_adelanto_comparacion
// Description : Directed self-checking bench for the branch-comparison
//               forwarding controller. A second instance with a 2-bit counter
//               shares the stimulus to exercise saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidad_adelanto_comparacion;

    logic        clk;
    logic        reset;
    logic        Avanza;
    logic        Flush;
    logic [4:0]  Rs_Deco_Id;
    logic [4:0]  Rt_Deco_Id;
    logic        Es_Branch;
    logic        Usa_Rt;
    logic [4:0]  Rd_Deco_Id;
    logic        RegWrite_Deco;
    logic        MemRead_Deco;
    logic [1:0]  Sel_Rs;
    logic [1:0]  Sel_Rt;
    logic        Stall;
    logic [15:0] Cnt_Stall;
    logic [1:0]  Sel_Rs_s;
    logic [1:0]  Sel_Rt_s;
    logic        Stall_s;
    logic [1:0]  Cnt_Stall_s;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    unidad_adelanto_comparacion #(.REG_W(5), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .Avanza        (Avanza),
        .Flush         (Flush),
        .Rs_Deco_Id    (Rs_Deco_Id),
        .Rt_Deco_Id    (Rt_Deco_Id),
        .Es_Branch     (Es_Branch),
        .Usa_Rt        (Usa_Rt),
        .Rd_Deco_Id    (Rd_Deco_Id),
        .RegWrite_Deco (RegWrite_Deco),
        .MemRead_Deco  (MemRead_Deco),
        .Sel_Rs        (Sel_Rs),
        .Sel_Rt        (Sel_Rt),
        .Stall         (Stall),
        .Cnt_Stall     (Cnt_Stall)
    );

    unidad_adelanto_comparacion #(.REG_W(5), .CNT_W(2)) dut_sat (
        .clk           (clk),
        .reset         (reset),
        .Avanza        (Avanza),
        .Flush         (Flush),
        .Rs_Deco_Id    (Rs_Deco_Id),
        .Rt_Deco_Id    (Rt_Deco_Id),
        .Es_Branch     (Es_Branch),
        .Usa_Rt        (Usa_Rt),
        .Rd_Deco_Id    (Rd_Deco_Id),
        .RegWrite_Deco (RegWrite_Deco),
        .MemRead_Deco  (MemRead_Deco),
        .Sel_Rs        (Sel_Rs_s),
        .Sel_Rt        (Sel_Rt_s),
        .Stall         (Stall_s),
        .Cnt_Stall     (Cnt_Stall_s)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one edge and land 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in DECO and let combinational outputs settle
    task automatic drive(input logic br, input logic [4:0] rs,
                         input logic [4:0] rt, input logic usa,
                         input logic [4:0] rd, input logic rw,
                         input logic mr);
        Es_Branch     = br;
        Rs_Deco_Id    = rs;
        Rt_Deco_Id    = rt;
        Usa_Rt        = usa;
        Rd_Deco_Id    = rd;
        RegWrite_Deco = rw;
        MemRead_Deco  = mr;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset  = 1'b1;
        Avanza = 1'b1;
        Flush  = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_sel_rs", 32'(Sel_Rs), 32'd0);
        check("rst_sel_rt", 32'(Sel_Rt), 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_cnt", 32'(Cnt_Stall), 32'd0);
        check("rst_cnt_sat", 32'(Cnt_Stall_s), 32'd0);

        // Forward from EXE: ALU rd=5, then branch rs=5
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("fwd_exe_sel_rs", 32'(Sel_Rs), 32'd1);
        check("fwd_exe_stall", 32'(Stall), 32'd0);
        check("fwd_exe_sel_rt", 32'(Sel_Rt), 32'd0);
        idle(2);

        // Load-use: load rd=7, then branch rs=3 rt=7
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd3, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        check("lu_stall", 32'(Stall), 32'd1);
        tick();
        exp_cnt++;
        check("lu_cnt", 32'(Cnt_Stall), 32'(exp_cnt));
        check("lu_stall_drop", 32'(Stall), 32'd0);
        check("lu_sel_rt_mem", 32'(Sel_Rt), 32'd2);
        check("lu_sel_rs", 32'(Sel_Rs), 32'd0);
        idle(2);

        // Priority: rd=4 in both MEM and EXE, then only in MEM
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("prio_exe_over_mem", 32'(Sel_Rs), 32'd1);
        tick();
        check("prio_mem_only", 32'(Sel_Rs), 32'd2);
        idle(2);

        // Register zero and Usa_Rt: MEM ALU rd=0, EXE load rd=6
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0);
        check("r0_sel_rs", 32'(Sel_Rs), 32'd0);
        check("r0_sel_rt", 32'(Sel_Rt), 32'd0);
        check("r0_stall", 32'(Stall), 32'd0);
        drive(1'b0, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
        check("nobranch_stall", 32'(Stall), 32'd0);
        check("nobranch_sel_rs", 32'(Sel_Rs), 32'd0);
        idle(2);

        // Freeze: load rd=9 in EXE, branch rs=9, Avanza low for 3 cycles
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        Avanza = 1'b0;
        drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("frz_stall_0", 32'(Stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("frz_stall_%0d", i + 1), 32'(Stall), 32'd1);
            check($sformatf("frz_cnt_%0d", i + 1), 32'(Cnt_Stall), 32'(exp_cnt));
        end
        // Release with Flush in the same cycle as the stall: still counts
        Avanza = 1'b1;
        Flush  = 1'b1;
        #1;
        tick();
        exp_cnt++;
        check("flush_stall_cnt", 32'(Cnt_Stall), 32'(exp_cnt));
        check("frz_mem_sel", 32'(Sel_Rs), 32'd2);
        // Flush an ALU rd=2: EXE must receive a bubble
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        tick();
        Flush = 1'b0;
        drive(1'b1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("flush_bubble_sel_rs", 32'(Sel_Rs), 32'd0);
        check("flush_bubble_stall", 32'(Stall), 32'd0);
        idle(2);

        // Saturation: fresh reset, then 5 load-use stalls
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        exp_cnt = 0;
        #1;
        check("sat_rst_cnt", 32'(Cnt_Stall_s), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
            tick();
            drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            check($sformatf("sat_stall_%0d", i), 32'(Stall_s), 32'd1);
            tick();
            exp_cnt++;
        end
        check("sat_cnt_wide", 32'(Cnt_Stall), 32'(exp_cnt));
        check("sat_cnt_narrow", 32'(Cnt_Stall_s), 32'd3);

        // Reset mid-stall: tag lost, stall drops, counter clears
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("midrst_stall_before", 32'(Stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("midrst_stall", 32'(Stall), 32'd0);
        check("midrst_cnt", 32'(Cnt_Stall), 32'd0);
        check("midrst_cnt_sat", 32'(Cnt_Stall_s), 32'd0);
        check("midrst_sel_rs", 32'(Sel_Rs), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unidad_adelanto_comparacion.md
# unidad_adelanto_comparacion

- Forwarding and hazard controller for the branch-comparison operand muxes in DECO.
- Keeps a shadow pipeline of destination-register tags for the instructions in EXE and MEM.
- Drives the 2-bit selectors of the Rs and Rt comparison muxes.
- Raises a stall when a branch in DECO depends on a load that is still in EXE, and counts stalls for performance debug.

## Interface
Parameters:
- REG_W, 5, register-index width
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- Avanza  in  1  pipeline advance enable; 0 freezes all stages (external memory wait)
- Flush  in  1  instruction in DECO is squashed this cycle
- Rs_Deco_Id  in  REG_W  rs index of instruction in DECO
- Rt_Deco_Id  in  REG_W  rt index of instruction in DECO
- Es_Branch  in  1  DECO instruction is a compare/branch
- Usa_Rt  in  1  comparison uses rt (0: rs vs zero)
- Rd_Deco_Id  in  REG_W  destination index of DECO instruction
- RegWrite_Deco  in  1  DECO instruction writes a register
- MemRead_Deco  in  1  DECO instruction is a load
- Sel_Rs  out  2  selector for the Rs comparison mux: 00 DECO, 01 EXE, 10 MEM
- Sel_Rt  out  2  selector for the Rt comparison mux, same encoding
- Stall  out  1  hold PC and DECO, insert bubble into EXE
- Cnt_Stall  out  CNT_W  saturating count of stall cycles

## Operation
- Shadow slots: EXE = {valid, rd, load} and MEM = {valid, rd, load}.
- A slot matches source s when valid && rd == s && s != 0. Register 0 is never forwarded.
- Selector for each source (Sel_Rt uses the same rule; forced to 00 when Usa_Rt=0 or Es_Branch=0):
  - EXE match with load=0 → 01.
  - Else MEM match → 10, for load or ALU alike, since MEM data includes load data.
  - Else → 00.
  - EXE has priority over MEM.
- Sel_Rs is 00 when Es_Branch=0.
- Stall = Es_Branch && an EXE match with load=1 on rs, or on rt when Usa_Rt=1. Sel outputs are don't-care during Stall.
- Register update, only when Avanza=1:
  - MEM ← EXE.
  - EXE ← bubble (valid=0) if Stall or Flush; otherwise {RegWrite_Deco, Rd_Deco_Id, MemRead_Deco}.
- Avanza=0: both slots hold and outputs keep being evaluated from the held state.
- Stall is not asserted to the pipeline as an advance by itself. The pipeline treats Stall as holding DECO, while the controller advances EXE→MEM normally.
- Cnt_Stall increments when Stall && Avanza. It saturates at all ones.

## Timing
- Sel_Rs, Sel_Rt and Stall are combinational from the shadow slots plus the current DECO inputs. They are valid in the same cycle the comparison mux is used.
- Shadow state updates on the rising edge of clk.
- A load-use stall lasts exactly 1 cycle when Avanza=1. On the next cycle the load sits in MEM and the selector becomes 10.
- The WB stage is not tracked; the register file bypasses write-to-read internally.
- Reset: both slots valid=0, Cnt_Stall=0. Hence Sel_Rs=Sel_Rt=00 and Stall=0 in the cycle after reset.
- Reset mid-stall: state clears, stall drops, and the pending load's tag is lost, because the pipeline is also reset.
- Flush and Stall in the same cycle: a bubble enters EXE, and the counter still increments.
- Avanza=0 during a stall: Stall stays 1 and the counter does not increment.

## Structure
- The shared package holds:
  - SEL_DECO=2'b00, SEL_EXE=2'b01, SEL_MEM=2'b10
  - the slot struct {valid, rd, load}
- Sub-module `sel_adelanto`: a combinational per-source selector (source index, EXE slot, MEM slot → sel, load_hit). It is instantiated twice, for rs and rt.
- The top level holds the slot registers, the stall OR and the counter.

## Test plan
- Forward from EXE:
  - Cycle 0: ALU op rd=5 in DECO.
  - Cycle 1: branch rs=5.
  - Required: Sel_Rs=01, Stall=0.
- Load-use:
  - Cycle 0: load rd=7.
  - Cycle 1: branch rs=3, rt=7, Usa_Rt=1.
  - Required: cycle 1 Stall=1 and Cnt_Stall becomes 1; cycle 2 Stall=0 and Sel_Rt=10.
- Priority:
  - ALU rd=4 in MEM and ALU rd=4 in EXE, then branch rs=4.
  - Required: Sel_Rs=01.
- Register zero and Usa_Rt:
  - Slots hold rd=0 writes; branch rs=0 with Usa_Rt=0 and rt matching EXE.
  - Required: Sel_Rs=00, Sel_Rt=00, Stall=0.
- Freeze and flush:
  - Load rd=9 in EXE and Avanza=0 for 3 cycles with branch rs=9.
  - Required: Stall=1 throughout and Cnt_Stall unchanged.
  - Then Flush with ALU rd=2 in DECO.
  - Required: EXE receives a bubble, so a following branch rs=2 sees Sel_Rs=00.
- Saturation and reset:
  - CNT_W=2 with 5 stall cycles.
  - Required: Cnt_Stall=3.
  - Assert reset mid-stall.
  - Required: next cycle Stall=0, Cnt_Stall=0.
